// File: rtl/shift_reg_burst.sv
// Universal WIDTH-bit shift register with a counted burst-shift controller.
// Optional rotate input enabled by defining SHIFT_REG_BURST_ROTATE_EN.

module shift_reg_burst_cell (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic shift,
   input  logic dir,
   input  logic d_bit,
   input  logic lo_bit,
   input  logic hi_bit,
   output logic q_bit
);
   // lo_bit is the lower neighbour (left shift source), hi_bit the upper one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     q_bit <= 1'b0;
      else if (load)  q_bit <= d_bit;
      else if (shift) q_bit <= dir ? hi_bit : lo_bit;
   end
endmodule

module shift_reg_burst #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic             dir,
   input  logic             sin,
   input  logic             start,
   input  logic [CNT_W-1:0] count,
`ifdef SHIFT_REG_BURST_ROTATE_EN
   input  logic             rot,
`endif
   output logic [WIDTH-1:0] q,
   output logic             sout,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] remaining, remaining_nx;
   logic             dir_l, dir_l_nx;
   logic             shift_go, eff_dir, out_bit, fb;
   logic [WIDTH-1:0] lo_vec, hi_vec;

   always_comb begin
      state_nx     = state;
      remaining_nx = remaining;
      dir_l_nx     = dir_l;
      shift_go     = 1'b0;
      if (load) begin
         state_nx     = IDLE;
         remaining_nx = '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  remaining_nx = count;
                  dir_l_nx     = dir;
                  state_nx     = (count != '0) ? SHIFT : DONE;
               end else if (en) begin
                  shift_go = 1'b1;
               end
            end
            SHIFT: begin
               if (en) begin
                  shift_go     = 1'b1;
                  remaining_nx = remaining - CNT_W'(1);
                  if (remaining == CNT_W'(1)) state_nx = DONE;
               end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   // Bursts use the direction captured at start; idle shifts follow live dir
   assign eff_dir = (state == SHIFT) ? dir_l : dir;
   assign out_bit = eff_dir ? q[0] : q[WIDTH-1];

`ifdef SHIFT_REG_BURST_ROTATE_EN
   logic rot_l, rot_l_nx, eff_rot;
   assign rot_l_nx = (!load && state == IDLE && start) ? rot : rot_l;
   assign eff_rot  = (state == SHIFT) ? rot_l : rot;
   assign fb       = eff_rot ? out_bit : sin;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rot_l <= 1'b0;
      else        rot_l <= rot_l_nx;
   end
`else
   assign fb = sin;
`endif

   assign lo_vec = {q[WIDTH-2:0], fb};
   assign hi_vec = {fb, q[WIDTH-1:1]};

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      shift_reg_burst_cell u_cell (
         .clk    (clk),
         .rst_n  (rst_n),
         .load   (load),
         .shift  (shift_go),
         .dir    (eff_dir),
         .d_bit  (d[i]),
         .lo_bit (lo_vec[i]),
         .hi_bit (hi_vec[i]),
         .q_bit  (q[i])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         remaining <= '0;
         dir_l     <= 1'b0;
         sout      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nx;
         remaining <= remaining_nx;
         dir_l     <= dir_l_nx;
         if (shift_go) sout <= out_bit;
         busy      <= (state_nx == SHIFT);
         done      <= (state_nx == DONE);
      end
   end

endmodule
